// File: rtl/fb_pkg.sv
// fb_pkg: shared types and framebuffer geometry for the framebuffer arbiter.
// Contents: grant encoding, screen dimensions, pixel address/data widths,
//           and the buffered CPU write record {addr, data}.
package fb_pkg;

  localparam int FB_WIDTH  = 480;
  localparam int FB_HEIGHT = 320;
  localparam int FB_ADDR_W = 18;  // 480*320 = 153600 pixels
  localparam int FB_DATA_W = 8;

  // What the RAM port was given on the previous cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: circular buffer of pending CPU pixel writes {addr, data}.
// Latency: an entry pushed this cycle is visible at the head next cycle.
// Backpressure: push ignored when full; a same-cycle pop does not free space.
// Ports: clk/reset, push_vld/push_addr/push_dat, pop, head_addr/head_dat,
//        empty, full, count (occupancy).
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign {head_addr, head_dat} = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_vld && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr, push_dat};
  end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port pixel RAM between VGA reads (absolute
//   priority) and buffered CPU writes drained on cycles with no read.
// Latency: read req -> vga_rd_valid 2 cycles; write push -> mem_we 2 cycles min.
// Backpressure: cpu_wr_ready low when the write FIFO is full or in reset;
//   VGA reads are never stalled. wr_starved is sticky until reset.
// Ports: cpu_wr_* (valid/ready write), vga_rd_* (read req/return),
//   mem_* (registered RAM port, rdata returns 1 cycle after the grant),
//   fifo_count (occupancy), wr_starved.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_wr_valid,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [DATA_W-1:0]             cpu_wr_data,
  output logic                          cpu_wr_ready,
  input  logic                          vga_rd_req,
  input  logic [ADDR_W-1:0]             vga_rd_addr,
  output logic [DATA_W-1:0]             vga_rd_data,
  output logic                          vga_rd_valid,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wr_starved
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_C = SC_W'(STARVE_LIMIT);

  grant_t              gnt_q, gnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_dat_q, rd_dat_d;
  logic [SC_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic                starved_q, starved_d;

  logic                fifo_push, fifo_pop;
  logic                fifo_empty, fifo_full;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_dat;

  // Ready looks only at the registered count, so a drain in the same cycle
  // never opens a slot early.
  assign cpu_wr_ready = !reset && !fifo_full;
  assign fifo_push    = cpu_wr_valid && cpu_wr_ready;

  fb_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_vld  (fifo_push),
    .push_addr (cpu_wr_addr),
    .push_dat  (cpu_wr_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_dat  (head_dat),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    gnt_d       = GNT_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    fifo_pop    = 1'b0;

    // Only entries already in the FIFO are eligible, so a fresh push
    // reaches the RAM no earlier than the following cycle.
    if (vga_rd_req) begin
      gnt_d      = GNT_RD;
      mem_addr_d = vga_rd_addr;
    end else if (!fifo_empty) begin
      gnt_d       = GNT_WR;
      mem_addr_d  = head_addr;
      mem_wdata_d = head_dat;
      mem_we_d    = 1'b1;
      fifo_pop    = 1'b1;
    end

    // RAM data for last cycle's read grant is present now; capture it.
    rd_vld_d = (gnt_q == GNT_RD);
    rd_dat_d = rd_vld_d ? mem_rdata : rd_dat_q;

    starve_cnt_d = starve_cnt_q;
    if (gnt_d == GNT_WR) begin
      starve_cnt_d = '0;
    end else if (vga_rd_req && !fifo_empty && (starve_cnt_q != STARVE_C)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starved_d = starved_q || (starve_cnt_d == STARVE_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q        <= GNT_IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rd_vld_q     <= 1'b0;
      rd_dat_q     <= '0;
      starve_cnt_q <= '0;
      starved_q    <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_vld_q     <= rd_vld_d;
      rd_dat_q     <= rd_dat_d;
      starve_cnt_q <= starve_cnt_d;
      starved_q    <= starved_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign vga_rd_valid = rd_vld_q;
  assign vga_rd_data  = rd_dat_q;
  assign wr_starved   = starved_q;

endmodule
